// File: rtl/digit_scan_timer_if.sv
// digit_scan_timer_if : control and scan-output bundle of the display timebase (rev 1.0)
`default_nettype none

interface digit_scan_timer_if #(
   parameter int CNT_W      = 10,
   parameter int NUM_DIGITS = 6
);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic                  en;
   logic                  sync_clr;
   logic [CNT_W-1:0]      period;
   logic [CNT_W-1:0]      dp_count;
   logic [IDX_W-1:0]      digit_idx;
   logic [NUM_DIGITS-1:0] digit_sel;
   logic                  blank;
   logic                  slot_tick;
   logic                  frame_tick;

   modport master (
      output en, sync_clr, period,
      input  dp_count, digit_idx, digit_sel, blank, slot_tick, frame_tick
   );

   modport slave (
      input  en, sync_clr, period,
      output dp_count, digit_idx, digit_sel, blank, slot_tick, frame_tick
   );
endinterface

`default_nettype wire

// File: rtl/digit_scan_timer.sv
// digit_scan_timer : programmable digit-slot prescaler and one-hot digit scanner (rev 1.0)
`default_nettype none

module digit_scan_timer #(
   parameter int CNT_W          = 10,
   parameter int NUM_DIGITS     = 6,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               hard_reset,
   digit_scan_timer_if.slave  bus
);
   localparam int                 IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   if (CNT_W < 2 || CNT_W > 24) begin : g_bad_cnt_w
      $error("digit_scan_timer: CNT_W out of range 2..24");
   end
   if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
      $error("digit_scan_timer: NUM_DIGITS out of range 2..16");
   end
   if (BLANK_CYCLES < 0 || BLANK_CYCLES >= (1 << CNT_W)) begin : g_bad_blank
      $error("digit_scan_timer: BLANK_CYCLES must fit below 2**CNT_W");
   end

   logic [CNT_W-1:0]      r_count;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_slot_tick;
   logic                  r_frame_tick;
   logic                  w_blank;
   logic [NUM_DIGITS-1:0] w_onehot;

   // The >= compare lets a shrinking period end the slot on the next edge.
   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         r_count      <= '0;
         r_idx        <= '0;
         r_slot_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else if (bus.sync_clr) begin
         r_count      <= '0;
         r_idx        <= '0;
         r_slot_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else if (!bus.en) begin
         r_slot_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else if (r_count >= bus.period) begin
         r_count      <= '0;
         r_slot_tick  <= 1'b1;
         r_frame_tick <= (r_idx == LAST_IDX);
         r_idx        <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_count      <= r_count + CNT_W'(1);
         r_slot_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
      end
   end

   if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank = 1'b0;
   end else begin : g_blank
      localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES);
      assign w_blank = (r_count < BLANK_TC);
   end

   always_comb begin
      w_onehot = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         w_onehot[d] = ~w_blank & (r_idx == IDX_W'(d));
      end
   end

   if (SEL_ACTIVE_LOW != 0) begin : g_sel_low
      assign bus.digit_sel = ~w_onehot;
   end else begin : g_sel_high
      assign bus.digit_sel = w_onehot;
   end

   assign bus.dp_count   = r_count;
   assign bus.digit_idx  = r_idx;
   assign bus.blank      = w_blank;
   assign bus.slot_tick  = r_slot_tick;
   assign bus.frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_timer.sv
// tb_digit_scan_timer : directed-vector bench for three digit_scan_timer configurations (rev 1.0)
`default_nettype none

module tb_digit_scan_timer;
   logic clk;
   logic hard_reset;
   int   n_vec;
   int   n_err;

   digit_scan_timer_if #(.CNT_W(10), .NUM_DIGITS(6)) bus_a ();
   digit_scan_timer_if #(.CNT_W(10), .NUM_DIGITS(6)) bus_b ();
   digit_scan_timer_if #(.CNT_W(4),  .NUM_DIGITS(2)) bus_c ();

   digit_scan_timer #(.CNT_W(10), .NUM_DIGITS(6), .BLANK_CYCLES(16), .SEL_ACTIVE_LOW(1))
      dut_a (.clk(clk), .hard_reset(hard_reset), .bus(bus_a));
   digit_scan_timer #(.CNT_W(10), .NUM_DIGITS(6), .BLANK_CYCLES(2), .SEL_ACTIVE_LOW(0))
      dut_b (.clk(clk), .hard_reset(hard_reset), .bus(bus_b));
   digit_scan_timer #(.CNT_W(4), .NUM_DIGITS(2), .BLANK_CYCLES(0), .SEL_ACTIVE_LOW(1))
      dut_c (.clk(clk), .hard_reset(hard_reset), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      int idx;
      int blk;
      n_vec = 0;
      n_err = 0;
      hard_reset = 1'b1;
      bus_a.en = 1'b0; bus_a.sync_clr = 1'b0; bus_a.period = '0;
      bus_b.en = 1'b0; bus_b.sync_clr = 1'b0; bus_b.period = '0;
      bus_c.en = 1'b0; bus_c.sync_clr = 1'b0; bus_c.period = '0;
      #2;
      chk("rst_a_cnt",   bus_a.dp_count,   0);
      chk("rst_a_idx",   bus_a.digit_idx,  0);
      chk("rst_a_blank", bus_a.blank,      1);
      chk("rst_a_sel",   bus_a.digit_sel,  6'b111111);
      chk("rst_a_slot",  bus_a.slot_tick,  0);
      chk("rst_a_frame", bus_a.frame_tick, 0);
      chk("rst_b_sel",   bus_b.digit_sel,  6'b000000);
      chk("rst_c_blank", bus_c.blank,      0);
      chk("rst_c_sel",   bus_c.digit_sel,  2'b10);

      @(negedge clk);
      hard_reset = 1'b0;
      bus_a.period = 10'd3;
      bus_a.en = 1'b1;

      // Basic scan, period 3: whole slot is blank because BLANK_CYCLES exceeds it.
      for (int n = 1; n <= 47; n++) begin
         step();
         chk("scan_cnt",   bus_a.dp_count,   n % 4);
         chk("scan_idx",   bus_a.digit_idx,  (n / 4) % 6);
         chk("scan_slot",  bus_a.slot_tick,  (n % 4) == 0);
         chk("scan_frame", bus_a.frame_tick, (n % 24) == 0);
         chk("scan_sel",   bus_a.digit_sel,  6'b111111);
      end

      // sync_clr on the digit-5 wrap edge.
      bus_a.sync_clr = 1'b1;
      step();
      chk("clr_cnt",   bus_a.dp_count,   0);
      chk("clr_idx",   bus_a.digit_idx,  0);
      chk("clr_slot",  bus_a.slot_tick,  0);
      chk("clr_frame", bus_a.frame_tick, 0);
      bus_a.sync_clr = 1'b0;
      step();
      step();
      chk("clr_resume_cnt", bus_a.dp_count, 2);
      bus_a.en = 1'b0;
      bus_a.sync_clr = 1'b1;
      step();
      chk("clr_dis_cnt", bus_a.dp_count,  0);
      chk("clr_dis_idx", bus_a.digit_idx, 0);

      // Period shrink below the running count, then period 0.
      bus_a.sync_clr = 1'b0;
      bus_a.en = 1'b1;
      bus_a.period = 10'd300;
      repeat (200) step();
      chk("long_cnt",   bus_a.dp_count,  200);
      chk("long_idx",   bus_a.digit_idx, 0);
      chk("long_blank", bus_a.blank,     0);
      chk("long_sel",   bus_a.digit_sel, 6'b111110);
      bus_a.period = 10'd50;
      step();
      chk("shrink_cnt",   bus_a.dp_count,   0);
      chk("shrink_idx",   bus_a.digit_idx,  1);
      chk("shrink_slot",  bus_a.slot_tick,  1);
      chk("shrink_frame", bus_a.frame_tick, 0);
      chk("shrink_sel",   bus_a.digit_sel,  6'b111111);
      repeat (20) step();
      chk("p50_cnt",   bus_a.dp_count,  20);
      chk("p50_blank", bus_a.blank,     0);
      chk("p50_sel",   bus_a.digit_sel, 6'b111101);
      chk("p50_slot",  bus_a.slot_tick, 0);
      bus_a.period = 10'd0;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("p0_cnt",   bus_a.dp_count,   0);
         chk("p0_idx",   bus_a.digit_idx,  (1 + k) % 6);
         chk("p0_slot",  bus_a.slot_tick,  1);
         chk("p0_frame", bus_a.frame_tick, ((1 + k) % 6) == 0);
      end

      // Blanking window with active-high selects, period 7.
      bus_b.period = 10'd7;
      bus_b.en = 1'b1;
      for (int n = 1; n <= 29; n++) begin
         step();
         cnt = n % 8;
         idx = (n / 8) % 6;
         blk = (cnt < 2) ? 1 : 0;
         chk("blank_cnt",  bus_b.dp_count,  cnt);
         chk("blank_idx",  bus_b.digit_idx, idx);
         chk("blank_flag", bus_b.blank,     blk);
         chk("blank_sel",  bus_b.digit_sel, blk ? 0 : (1 << idx));
         chk("blank_slot", bus_b.slot_tick, cnt == 0);
      end

      // Enable freeze at count 5, digit 3.
      bus_b.en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("frz_cnt",   bus_b.dp_count,   5);
         chk("frz_idx",   bus_b.digit_idx,  3);
         chk("frz_slot",  bus_b.slot_tick,  0);
         chk("frz_frame", bus_b.frame_tick, 0);
      end
      chk("frz_sel", bus_b.digit_sel, 6'b001000);
      bus_b.en = 1'b1;
      step();
      chk("frz_resume_cnt", bus_b.dp_count,  6);
      chk("frz_resume_idx", bus_b.digit_idx, 3);

      // Two digits, 4-bit prescaler, no blanking.
      bus_c.period = 4'd15;
      bus_c.en = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         step();
         idx = (n / 16) % 2;
         chk("two_cnt",   bus_c.dp_count,   n % 16);
         chk("two_idx",   bus_c.digit_idx,  idx);
         chk("two_blank", bus_c.blank,      0);
         chk("two_sel",   bus_c.digit_sel,  idx ? 2'b01 : 2'b10);
         chk("two_frame", bus_c.frame_tick, (n % 32) == 0);
      end

      // Asynchronous reset mid-slot, no clock edge in between.
      #2;
      hard_reset = 1'b1;
      #1;
      chk("arst_a_cnt",   bus_a.dp_count,  0);
      chk("arst_a_idx",   bus_a.digit_idx, 0);
      chk("arst_a_slot",  bus_a.slot_tick, 0);
      chk("arst_a_blank", bus_a.blank,     1);
      chk("arst_c_cnt",   bus_c.dp_count,  0);
      chk("arst_b_idx",   bus_b.digit_idx, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
